dpmem_vga: RTL and testbench

Parametrised dual-port word memory shared between the processor datapath and the VGA controller. The CPU port does registered single-word reads and byte-masked writes with address decode and an alignment/range error flag. The VGA port is read-only and streams bursts of consecutive words from a start index, one word per cycle, with wrap-around at the top of memory. It sits between the vector processor's load/store unit and the VGA pixel fetch logic, and replaces the fixed 32-bit single-read-port framebuffer memory.

---
 rtl/dpmem_vga_if.sv | 41 ++++
 rtl/dpmem_vga.sv | 158 +++++++++++++++
 tb/tb_dpmem_vga.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dpmem_vga_if.sv
// CPU and VGA port bundle for the shared framebuffer memory.
// The memory side uses the slave modport; the requesting side uses master.
interface dpmem_vga_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 17000,
    parameter int BURST_W = 10
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                  cpu_read;
    logic                  cpu_write;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W/8-1:0]   cpu_be;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_rvalid;
    logic                  cpu_err;

    logic                  vga_start;
    logic [IDX_W-1:0]      vga_addr;
    logic [BURST_W-1:0]    vga_len;
    logic                  vga_busy;
    logic [DATA_W-1:0]     vga_data;
    logic                  vga_valid;
    logic                  vga_done;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_be, cpu_wdata,
        input  cpu_rdata, cpu_rvalid, cpu_err,
        output vga_start, vga_addr, vga_len,
        input  vga_busy, vga_data, vga_valid, vga_done
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_be, cpu_wdata,
        output cpu_rdata, cpu_rvalid, cpu_err,
        input  vga_start, vga_addr, vga_len,
        output vga_busy, vga_data, vga_valid, vga_done
    );
endinterface

// File: rtl/dpmem_vga.sv
// Dual-port word memory: CPU read/write port plus VGA read-only burst port.
// Optional macro MEMDP_BYTE_WRITE_EN enables per-lane cpu_be write masking.
//   state   | meaning
//   S_IDLE  | no burst; waiting for vga_start with non-zero length
//   S_BURST | streaming one word per cycle, cnt_q words still to go
module dpmem_vga #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 17000,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                BURST_W   = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    dpmem_vga_if.slave   bus
);
    localparam int                NB        = DATA_W / 8;
    localparam int                OFF_W     = $clog2(NB);
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] local_addr;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  cpu_idx;
    logic              cpu_ok;
    logic              wr_en;
    logic              rd_en;
    logic              err_d;

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              err_q;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] vdata_q;
    logic              vvalid_q, vvalid_d;
    logic              vdone_q, vdone_d;
    logic              busy;
    logic              start_ok;
    logic              last_beat;

    always_comb begin
        local_addr = bus.cpu_addr - BASE_ADDR;
        word_addr  = local_addr >> OFF_W;
        cpu_idx    = word_addr[IDX_W-1:0];
        cpu_ok     = ((local_addr & LANE_MASK) == '0) && (word_addr < DEPTH_A);
        wr_en      = reset_n & bus.cpu_write & cpu_ok;
        rd_en      = bus.cpu_read & ~bus.cpu_write & cpu_ok;
        err_d      = (bus.cpu_read | bus.cpu_write) & ~cpu_ok;
    end

    // Non-blocking write keeps both read ports read-first on a collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef MEMDP_BYTE_WRITE_EN
            for (int b = 0; b < NB; b++) begin
                if (bus.cpu_be[b]) begin
                    mem[cpu_idx][b*8 +: 8] <= bus.cpu_wdata[b*8 +: 8];
                end
            end
`else
            mem[cpu_idx] <= bus.cpu_wdata;
`endif
        end
    end

`ifndef MEMDP_BYTE_WRITE_EN
    logic unused_be;
    assign unused_be = ^bus.cpu_be;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            err_q    <= err_d;
            if (rd_en) begin
                rdata_q <= mem[cpu_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            vdata_q  <= '0;
            vvalid_q <= 1'b0;
            vdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            vvalid_q <= vvalid_d;
            vdone_q  <= vdone_d;
            if (state_q == S_BURST) begin
                vdata_q <= mem[ptr_q];
            end
        end
    end

    // A start seen on the final beat chains the next burst with no idle bubble.
    always_comb begin
        start_ok  = bus.vga_start && (bus.vga_len != '0);
        last_beat = (state_q == S_BURST) && (cnt_q == BURST_W'(1));
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_BURST;
                    ptr_d   = bus.vga_addr;
                    cnt_d   = bus.vga_len;
                end
            end
            S_BURST: begin
                ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
                cnt_d = cnt_q - BURST_W'(1);
                if (last_beat) begin
                    if (start_ok) begin
                        ptr_d = bus.vga_addr;
                        cnt_d = bus.vga_len;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vvalid_d = (state_q == S_BURST);
        vdone_d  = last_beat;
        busy     = (state_q == S_BURST);
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_err    = err_q;
    assign bus.vga_data   = vdata_q;
    assign bus.vga_valid  = vvalid_q;
    assign bus.vga_done   = vdone_q;
    assign bus.vga_busy   = busy;
endmodule

// File: tb/tb_dpmem_vga.sv
// Bench for dpmem_vga: CPU vector table, directed VGA sequences, random traffic
// checked against a queue-based reference model.
module tb_dpmem_vga;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          DEP  = 40;
    localparam int          BW   = 10;
    localparam logic [31:0] BASE = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dpmem_vga_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BURST_W(BW)) bus ();

    dpmem_vga #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE), .BURST_W(BW)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // Reference model: word array plus a queue of word indices still to stream.
    logic [31:0] m_mem [DEP];
    int          q_idx [$];
    logic [31:0] e_rdata, e_vdata;
    logic        e_rvalid, e_err, e_vvalid, e_vdone, e_busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          x_rvalid;
        bit          x_err;
        logic [31:0] x_rdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic [31:0] lcl;
        int          qs;
        int          widx;
        bit          ok;
        if (!rst_n) begin
            q_idx.delete();
            e_rdata = '0; e_rvalid = 1'b0; e_err = 1'b0;
            e_vdata = '0; e_vvalid = 1'b0; e_vdone = 1'b0;
        end else begin
            qs = q_idx.size();
            if (qs > 0) begin
                e_vdata  = m_mem[q_idx.pop_front()];
                e_vvalid = 1'b1;
                e_vdone  = (q_idx.size() == 0);
            end else begin
                e_vvalid = 1'b0;
                e_vdone  = 1'b0;
            end
            if (bus.vga_start && bus.vga_len != 0 && qs <= 1) begin
                for (int i = 0; i < int'(bus.vga_len); i++)
                    q_idx.push_back((int'(bus.vga_addr) + i) % DEP);
            end
            lcl  = bus.cpu_addr - BASE;
            ok   = (lcl % 4 == 0) && (lcl / 4 < DEP);
            widx = int'(lcl / 4);
            e_rvalid = 1'b0;
            e_err    = 1'b0;
            if ((bus.cpu_read || bus.cpu_write) && !ok) begin
                e_err = 1'b1;
            end else if (bus.cpu_write) begin
`ifdef MEMDP_BYTE_WRITE_EN
                for (int b = 0; b < 4; b++)
                    if (bus.cpu_be[b]) m_mem[widx][b*8 +: 8] = bus.cpu_wdata[b*8 +: 8];
`else
                m_mem[widx] = bus.cpu_wdata;
`endif
            end else if (bus.cpu_read) begin
                e_rdata  = m_mem[widx];
                e_rvalid = 1'b1;
            end
        end
        e_busy = (q_idx.size() > 0);
        @(posedge clk);
        #1;
        chk("cpu_rdata",  bus.cpu_rdata,  e_rdata);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_rvalid));
        chk("cpu_err",    32'(bus.cpu_err),    32'(e_err));
        chk("vga_valid",  32'(bus.vga_valid),  32'(e_vvalid));
        chk("vga_done",   32'(bus.vga_done),   32'(e_vdone));
        chk("vga_busy",   32'(bus.vga_busy),   32'(e_busy));
        chk("vga_data",   bus.vga_data,   e_vdata);
    endtask

    task automatic cpu_idle();
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_addr = '0;   bus.cpu_be = '0; bus.cpu_wdata = '0;
    endtask

    task automatic vga(input bit s, input int a, input int n);
        bus.vga_start = s;
        bus.vga_addr  = 6'(a);
        bus.vga_len   = 10'(n);
    endtask

    task automatic exp_vga(input string nm, input bit v, input bit d, input bit b, input logic [31:0] data);
        chk({nm, ".valid"}, 32'(bus.vga_valid), 32'(v));
        chk({nm, ".done"},  32'(bus.vga_done),  32'(d));
        chk({nm, ".busy"},  32'(bus.vga_busy),  32'(b));
        if (v) chk({nm, ".data"}, bus.vga_data, data);
    endtask

    vec_t        vt [$];
    logic [31:0] r_lane;

    initial begin
        rst_n = 1'b0;
        cpu_idle();
        vga(1'b0, 0, 0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < DEP; i++) begin
            bus.cpu_write = 1'b1; bus.cpu_addr = 32'(i * 4);
            bus.cpu_be = 4'hF;    bus.cpu_wdata = 32'(i);
            step();
        end
        cpu_idle();

`ifdef MEMDP_BYTE_WRITE_EN
        r_lane = 32'h11BB33DD;
`else
        r_lane = 32'hAABBCCDD;
`endif
        vt.push_back('{0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0});
        vt.push_back('{1, 0, 32'h10, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF});
        vt.push_back('{0, 1, 32'h10, 4'hF, 32'h11223344, 0, 0, 32'hDEADBEEF});
        vt.push_back('{0, 1, 32'h10, 4'h5, 32'hAABBCCDD, 0, 0, 32'hDEADBEEF});
        vt.push_back('{1, 0, 32'h10, 4'h0, 32'h0,        1, 0, r_lane});
        vt.push_back('{1, 0, 32'h12, 4'h0, 32'h0,        0, 1, r_lane});
        vt.push_back('{1, 0, 32'(4*DEP), 4'h0, 32'h0,    0, 1, r_lane});
        vt.push_back('{0, 1, 32'h12, 4'hF, 32'h55555555, 0, 1, r_lane});
        vt.push_back('{1, 0, 32'h10, 4'h0, 32'h0,        1, 0, r_lane});
        vt.push_back('{1, 1, 32'h14, 4'hF, 32'h12345678, 0, 0, r_lane});
        vt.push_back('{1, 0, 32'h14, 4'h0, 32'h0,        1, 0, 32'h12345678});
        vt.push_back('{1, 0, 32'(4*DEP-4), 4'h0, 32'h0,  1, 0, 32'(DEP-1)});
        vt.push_back('{0, 1, 32'(4*DEP-2), 4'hF, 32'h0,  0, 1, 32'(DEP-1)});
        vt.push_back('{1, 0, 32'hFFFFFFFC, 4'h0, 32'h0,  0, 1, 32'(DEP-1)});

        foreach (vt[k]) begin
            bus.cpu_read  = vt[k].rd;
            bus.cpu_write = vt[k].wr;
            bus.cpu_addr  = vt[k].addr;
            bus.cpu_be    = vt[k].be;
            bus.cpu_wdata = vt[k].wdata;
            step();
            chk($sformatf("vec%0d.rvalid", k), 32'(bus.cpu_rvalid), 32'(vt[k].x_rvalid));
            chk($sformatf("vec%0d.err", k),    32'(bus.cpu_err),    32'(vt[k].x_err));
            chk($sformatf("vec%0d.rdata", k),  bus.cpu_rdata,       vt[k].x_rdata);
        end
        cpu_idle();

        vga(1'b1, 3, 0); step(); exp_vga("len0", 0, 0, 0, 0);
        vga(1'b1, DEP-2, 4); step(); exp_vga("wrap.start", 0, 0, 1, 0);
        vga(1'b0, 0, 0);
        step(); exp_vga("wrap.w0", 1, 0, 1, 32'(DEP-2));
        step(); exp_vga("wrap.w1", 1, 0, 1, 32'(DEP-1));
        step(); exp_vga("wrap.w2", 1, 0, 1, 32'd0);
        step(); exp_vga("wrap.w3", 1, 1, 0, 32'd1);
        step(); exp_vga("wrap.after", 0, 0, 0, 0);

        vga(1'b1, 10, 3); step();
        vga(1'b0, 0, 0);
        step(); exp_vga("b2b.w0", 1, 0, 1, 32'd10);
        step(); exp_vga("b2b.w1", 1, 0, 1, 32'd11);
        vga(1'b1, 20, 2);
        bus.cpu_write = 1'b1; bus.cpu_addr = 32'(12*4); bus.cpu_be = 4'hF; bus.cpu_wdata = 32'hCAFEF00D;
        step(); exp_vga("b2b.w2_oldval", 1, 1, 1, 32'd12);
        vga(1'b0, 0, 0); cpu_idle();
        step(); exp_vga("b2b.n0", 1, 0, 1, 32'd20);
        bus.cpu_read = 1'b1; bus.cpu_addr = 32'(12*4);
        step(); exp_vga("b2b.n1", 1, 1, 0, 32'd21);
        chk("b2b.newval", bus.cpu_rdata, 32'hCAFEF00D);
        cpu_idle();

        vga(1'b1, 0, 10); step();
        vga(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        exp_vga("rst.mid", 1, 0, 1, 32'd3);
        rst_n = 1'b0; step(); exp_vga("rst.at", 0, 0, 0, 0);
        rst_n = 1'b1; step(); exp_vga("rst.after", 0, 0, 0, 0);
        vga(1'b1, 5, 2); step();
        vga(1'b0, 0, 0);
        step(); exp_vga("rst.new0", 1, 0, 1, 32'h12345678);
        step(); exp_vga("rst.new1", 1, 1, 0, 32'd6);

        for (int c = 0; c < 3000; c++) begin
            int r;
            rst_n = ($urandom_range(0, 199) != 0);
            r = $urandom_range(0, 9);
            bus.cpu_read  = (r < 4) || (r == 8);
            bus.cpu_write = (r >= 4 && r < 7) || (r == 8);
            r = $urandom_range(0, 15);
            if (r == 0)      bus.cpu_addr = 32'(4 * $urandom_range(0, DEP-1) + $urandom_range(1, 3));
            else if (r == 1) bus.cpu_addr = 32'(4 * $urandom_range(DEP, DEP + 8));
            else if (r == 2) bus.cpu_addr = $urandom;
            else             bus.cpu_addr = 32'(4 * $urandom_range(0, DEP-1));
            bus.cpu_be    = 4'($urandom);
            bus.cpu_wdata = $urandom;
            vga($urandom_range(0, 5) == 0, $urandom_range(0, DEP-1), $urandom_range(0, 12));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
